// File: rtl/coolgirl_config_ctrl_if.sv
// CPU-side bus seen by the CoolGirl configuration controller.
// The cartridge edge drives it and the controller only samples it.
interface coolgirl_config_ctrl_if;
    logic        romsel;
    logic        cpu_rw_in;
    logic [14:0] cpu_addr_in;
    logic [7:0]  cpu_data_in;

    modport master (output romsel, output cpu_rw_in, output cpu_addr_in, output cpu_data_in);
    modport slave  (input  romsel, input  cpu_rw_in, input  cpu_addr_in, input  cpu_data_in);
endinterface

// File: rtl/coolgirl_config_ctrl.sv
// CoolGirl mapping configuration: shadow registers in the $5000 window, an atomic
// commit to the live outputs, a two-byte flash-write key, and a one-way lockout.
module coolgirl_config_ctrl #(
    parameter logic [2:0] REG_PAGE     = 3'b101,
    parameter logic [7:0] PRG_KEY1     = 8'h55,
    parameter logic [7:0] PRG_KEY2     = 8'hAA,
    parameter logic       CHR_WE_RESET = 1'b1
) (
    input  logic                         m2,
    input  logic                         reset,
    coolgirl_config_ctrl_if.slave        bus,
    output logic [12:0]                  cpu_base,
    output logic [4:0]                   cpu_mask,
    output logic [4:0]                   chr_mask,
    output logic [1:0]                   sram_page,
    output logic [3:0]                   mapper,
    output logic                         sram_enabled,
    output logic                         chr_write_enabled,
    output logic                         prg_write_enabled,
    output logic                         lockout,
    output logic                         cfg_strobe
);
    typedef enum logic [1:0] {KEY_IDLE, KEY_K1, KEY_ARMED} key_state_t;

    key_state_t key_state, key_next;

    logic [12:0] sh_cpu_base;
    logic [4:0]  sh_cpu_mask;
    logic [4:0]  sh_chr_mask;
    logic [1:0]  sh_sram_page;
    logic [3:0]  sh_mapper;

    logic       regwr;
    logic [2:0] idx;
    logic [7:0] d;
    logic       unused_addr;

    // Lockout gates the decode itself, so nothing downstream can see a write.
    assign regwr = bus.romsel && !bus.cpu_rw_in &&
                   (bus.cpu_addr_in[14:12] == REG_PAGE) && !lockout;
    assign idx   = bus.cpu_addr_in[2:0];
    assign d     = bus.cpu_data_in;
    assign unused_addr = &{1'b0, bus.cpu_addr_in[11:3]};

    always_ff @(negedge m2 or negedge reset) begin
        if (!reset) key_state <= KEY_IDLE;
        else        key_state <= key_next;
    end

    always_comb begin
        key_next = key_state;
        if (regwr) begin
            case (idx)
                3'd5: key_next = KEY_IDLE;
                3'd6: begin
                    case (key_state)
                        KEY_IDLE:  key_next = (d == PRG_KEY1) ? KEY_K1 : KEY_IDLE;
                        KEY_K1:    key_next = (d == PRG_KEY2) ? KEY_ARMED : KEY_IDLE;
                        default:   key_next = KEY_IDLE;
                    endcase
                end
                default: key_next = key_state;
            endcase
        end
    end

    always_ff @(negedge m2 or negedge reset) begin
        if (!reset) begin
            sh_cpu_base       <= '0;
            sh_cpu_mask       <= '0;
            sh_chr_mask       <= '0;
            sh_sram_page      <= '0;
            sh_mapper         <= '0;
            cpu_base          <= '0;
            cpu_mask          <= '0;
            chr_mask          <= '0;
            sram_page         <= '0;
            mapper            <= '0;
            sram_enabled      <= 1'b0;
            chr_write_enabled <= CHR_WE_RESET;
            prg_write_enabled <= 1'b0;
            lockout           <= 1'b0;
            cfg_strobe        <= 1'b0;
        end else begin
            cfg_strobe <= regwr && (idx == 3'd5);
            if (regwr) begin
                case (idx)
                    3'd0: sh_cpu_base[12:8] <= d[4:0];
                    3'd1: sh_cpu_base[7:0]  <= d;
                    3'd2: sh_cpu_mask       <= d[4:0];
                    3'd3: sh_chr_mask       <= d[4:0];
                    3'd4: begin
                        sh_mapper    <= d[3:0];
                        sh_sram_page <= d[5:4];
                    end
                    3'd5: begin
                        cpu_base          <= sh_cpu_base;
                        cpu_mask          <= sh_cpu_mask;
                        chr_mask          <= sh_chr_mask;
                        sram_page         <= sh_sram_page;
                        mapper            <= sh_mapper;
                        sram_enabled      <= d[0];
                        chr_write_enabled <= d[1];
                        prg_write_enabled <= d[2] && (key_state == KEY_ARMED);
                        lockout           <= d[7];
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
